// File: rtl/mem_dcache.sv
// Direct-mapped, write-through, no-write-allocate MEM-stage data cache.
// One 32-bit word per line; stalls the pipeline while a bus refill or write-through is in flight.
module mem_dcache #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        stallreq_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 32 - INDEX_BITS - 2;

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } bus_t;

   state_t              state_q, state_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [31:0]         rbuf_q, rbuf_d;
   bus_t                bus_q, bus_d;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [31:0]         data_q [LINES];

   logic [INDEX_BITS-1:0] index, ref_idx, line_idx;
   logic [TAG_W-1:0]      tag, ref_tag, line_tag;
   logic [31:0]           merged, line_wdata;
   logic                  hit, line_we;
   logic                  unused_addr;

   assign index   = addr_i[INDEX_BITS+1:2];
   assign tag     = addr_i[31:INDEX_BITS+2];
   // Refill targets the line named by the latched bus address.
   assign ref_idx = bus_q.addr[INDEX_BITS+1:2];
   assign ref_tag = bus_q.addr[31:INDEX_BITS+2];
   assign hit     = ce_i && valid_q[index] && (tag_q[index] == tag);
   assign unused_addr = ^addr_i[1:0];

   always_comb begin
      merged = data_q[index];
      for (int k = 0; k < 4; k++)
         if (sel_i[k]) merged[8*k +: 8] = wdata_i[8*k +: 8];
   end

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      rbuf_d     = rbuf_q;
      bus_d      = bus_q;
      line_we    = 1'b0;
      line_idx   = index;
      line_tag   = tag;
      line_wdata = merged;
      stallreq_o = 1'b0;
      rdata_o    = 32'h0;
      case (state_q)
         IDLE: begin
            if (ce_i) begin
               if (we_i) begin
                  stallreq_o = 1'b1;
                  bus_d      = '{req: 1'b1, we: 1'b1, addr: addr_i, sel: sel_i, wdata: wdata_i};
                  state_d    = WR_WAIT;
               end else if (hit) begin
                  rdata_o = data_q[index];
               end else begin
                  stallreq_o = 1'b1;
                  bus_d      = '{req: 1'b1, we: 1'b0, addr: {addr_i[31:2], 2'b00},
                                 sel: 4'b1111, wdata: bus_q.wdata};
                  state_d    = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            stallreq_o = 1'b1;
            if (mem_ack_i) begin
               line_we          = 1'b1;
               line_idx         = ref_idx;
               line_tag         = ref_tag;
               line_wdata       = mem_rdata_i;
               valid_d[ref_idx] = 1'b1;
               rbuf_d           = mem_rdata_i;
               bus_d.req        = 1'b0;
               state_d          = DONE;
            end
         end
         WR_WAIT: begin
            stallreq_o = 1'b1;
            if (mem_ack_i) begin
               // Write-through only updates a resident line; misses never allocate.
               line_we   = hit;
               bus_d.req = 1'b0;
               state_d   = DONE;
            end
         end
         DONE: begin
            rdata_o = we_i ? 32'h0 : rbuf_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         valid_q <= '0;
         rbuf_q  <= '0;
         bus_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         rbuf_q  <= rbuf_d;
         bus_q   <= bus_d;
      end
   end

   // Tag/data arrays need no reset: valid bits gate every use.
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_q[line_idx]  <= line_tag;
         data_q[line_idx] <= line_wdata;
      end
   end

   assign mem_req_o   = bus_q.req;
   assign mem_we_o    = bus_q.we;
   assign mem_addr_o  = bus_q.addr;
   assign mem_sel_o   = bus_q.sel;
   assign mem_wdata_o = bus_q.wdata;

endmodule

// File: tb/tb_mem_dcache.sv
// Directed, table-driven bench for mem_dcache with a simple ack-latency bus model.
module tb_mem_dcache;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce_i, we_i;
   logic [31:0] addr_i, wdata_i;
   logic [3:0]  sel_i;
   logic [31:0] rdata_o;
   logic        stallreq_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_dcache #(.INDEX_BITS(6)) dut (
      .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
      .sel_i(sel_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stallreq_o(stallreq_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .mem_ack_i(mem_ack_i)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] ack_data;
      int          exp_stall;
      logic        exp_req;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(string name, logic we, logic [31:0] addr, logic [3:0] sel,
                               logic [31:0] wdata, int lat, logic [31:0] ack_data,
                               int exp_stall, logic exp_req, logic [31:0] exp_rdata);
      vec_t v;
      v.name = name; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
      v.lat = lat; v.ack_data = ack_data; v.exp_stall = exp_stall;
      v.exp_req = exp_req; v.exp_rdata = exp_rdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Starts just after a rising edge; returns just after the edge that consumes the access.
   task automatic run_vec(input vec_t v);
      int          stalls, req_cycles;
      bit          req_seen, done;
      logic        we_s;
      logic [31:0] addr_s, wd_s, rd;
      logic [3:0]  sel_s;
      stalls = 0; req_cycles = 0; req_seen = 0; done = 0;
      we_s = 0; addr_s = 0; wd_s = 0; sel_s = 0; rd = 0;
      ce_i = 1'b1; we_i = v.we; addr_i = v.addr; sel_i = v.sel; wdata_i = v.wdata;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (mem_req_o) begin
            if (!req_seen) begin
               we_s = mem_we_o; addr_s = mem_addr_o; sel_s = mem_sel_o; wd_s = mem_wdata_o;
            end
            req_seen = 1;
            req_cycles++;
            if (req_cycles == v.lat) begin
               mem_ack_i = 1'b1;
               mem_rdata_i = v.ack_data;
            end
         end
         if (stallreq_o) stalls++;
         else begin
            rd = rdata_o;
            done = 1;
         end
         @(posedge clk);
         #1;
         mem_ack_i = 1'b0;
         mem_rdata_i = 32'h0;
      end
      ce_i = 1'b0; we_i = 1'b0;
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL %s timeout: stall still high after 60 cycles, expected release", v.name);
      end else begin
         chk({v.name, " stall_cycles"}, stalls, v.exp_stall);
         chk({v.name, " bus_req"}, {31'b0, req_seen}, {31'b0, v.exp_req});
         if (v.exp_req) begin
            chk({v.name, " bus_we"}, {31'b0, we_s}, {31'b0, v.we});
            chk({v.name, " bus_addr"}, addr_s, {v.addr[31:2], 2'b00});
            chk({v.name, " bus_sel"}, {28'b0, sel_s}, v.we ? {28'b0, v.sel} : 32'hF);
            if (v.we) chk({v.name, " bus_wdata"}, wd_s, v.wdata);
         end
         chk({v.name, " rdata"}, rd, v.exp_rdata);
      end
   endtask

   initial begin
      //                name        we   addr          sel    wdata         L  ack_data      stall req  rdata
      vecs[0]  = mk("ld100_miss",  0, 32'h0000_0100, 4'hF, 32'h0,         3, 32'hDEAD_BEEF, 4, 1, 32'hDEAD_BEEF);
      vecs[1]  = mk("ld100_hit",   0, 32'h0000_0100, 4'hF, 32'h0,         1, 32'h0,         0, 0, 32'hDEAD_BEEF);
      vecs[2]  = mk("st100_hit",   1, 32'h0000_0100, 4'h3, 32'h0000_1234, 1, 32'h0,         2, 1, 32'h0);
      vecs[3]  = mk("ld100_merge", 0, 32'h0000_0100, 4'hF, 32'h0,         1, 32'h0,         0, 0, 32'hDEAD_1234);
      vecs[4]  = mk("st200_miss",  1, 32'h0000_0200, 4'hF, 32'hCAFE_F00D, 2, 32'h0,         3, 1, 32'h0);
      vecs[5]  = mk("ld100_noalc", 0, 32'h0000_0100, 4'hF, 32'h0,         1, 32'h0,         0, 0, 32'hDEAD_1234);
      vecs[6]  = mk("ld200_miss",  0, 32'h0000_0200, 4'hF, 32'h0,         1, 32'h1111_2222, 2, 1, 32'h1111_2222);
      vecs[7]  = mk("ld100_evict", 0, 32'h0000_0100, 4'hF, 32'h0,         2, 32'hAAAA_5555, 3, 1, 32'hAAAA_5555);
      vecs[8]  = mk("ld10100_cf",  0, 32'h0001_0100, 4'hF, 32'h0,         1, 32'h0101_0101, 2, 1, 32'h0101_0101);
      vecs[9]  = mk("ld100_cf",    0, 32'h0000_0100, 4'hF, 32'h0,         1, 32'h5A5A_5A5A, 2, 1, 32'h5A5A_5A5A);
      vecs[10] = mk("ld104_miss",  0, 32'h0000_0104, 4'hF, 32'h0,         2, 32'h4444_4444, 3, 1, 32'h4444_4444);
      vecs[11] = mk("ld104_hit",   0, 32'h0000_0104, 4'hF, 32'h0,         1, 32'h0,         0, 0, 32'h4444_4444);
      vecs[12] = mk("ld100_hit2",  0, 32'h0000_0100, 4'hF, 32'h0,         1, 32'h0,         0, 0, 32'h5A5A_5A5A);
      vecs[13] = mk("st104_hi",    1, 32'h0000_0104, 4'hC, 32'hBEEF_0000, 1, 32'h0,         2, 1, 32'h0);
      vecs[14] = mk("ld104_merge", 0, 32'h0000_0104, 4'hF, 32'h0,         1, 32'h0,         0, 0, 32'hBEEF_4444);
      vecs[15] = mk("st300_miss",  1, 32'h0000_0300, 4'h4, 32'h0077_0000, 3, 32'h0,         4, 1, 32'h0);
      vecs[16] = mk("ld100_keep",  0, 32'h0000_0100, 4'hF, 32'h0,         1, 32'h0,         0, 0, 32'h5A5A_5A5A);

      rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; sel_i = 4'h0; wdata_i = 32'h0;
      mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst stall", {31'b0, stallreq_o}, 32'h0);
      chk("rst rdata", rdata_o, 32'h0);
      chk("rst mem_req", {31'b0, mem_req_o}, 32'h0);
      chk("rst mem_we", {31'b0, mem_we_o}, 32'h0);
      chk("rst mem_addr", mem_addr_o, 32'h0);
      chk("rst mem_sel", {28'b0, mem_sel_o}, 32'h0);
      chk("rst mem_wdata", mem_wdata_o, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) run_vec(vecs[i]);

      // Idle with ce_i low and a stray ack: nothing may happen.
      addr_i = 32'h0000_0100; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
      @(negedge clk);
      chk("spur stall", {31'b0, stallreq_o}, 32'h0);
      chk("spur rdata", rdata_o, 32'h0);
      chk("spur mem_req", {31'b0, mem_req_o}, 32'h0);
      @(posedge clk); #1;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      @(negedge clk);
      chk("spur mem_req2", {31'b0, mem_req_o}, 32'h0);
      @(posedge clk); #1;
      run_vec(mk("ld100_after_spur", 0, 32'h0000_0100, 4'hF, 32'h0, 1, 32'h0, 0, 0, 32'h5A5A_5A5A));

      // Reset while a refill is outstanding, then a late ack.
      ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0108;
      @(negedge clk);
      @(negedge clk);
      chk("rdwait mem_req", {31'b0, mem_req_o}, 32'h1);
      rst = 1'b0; ce_i = 1'b0;
      #1;
      chk("midrst mem_req", {31'b0, mem_req_o}, 32'h0);
      chk("midrst mem_addr", mem_addr_o, 32'h0);
      chk("midrst stall", {31'b0, stallreq_o}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h9999_9999;
      @(posedge clk); #1;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      @(negedge clk);
      chk("lateack stall", {31'b0, stallreq_o}, 32'h0);
      chk("lateack mem_req", {31'b0, mem_req_o}, 32'h0);
      @(posedge clk); #1;
      run_vec(mk("ld100_postrst", 0, 32'h0000_0100, 4'hF, 32'h0, 1, 32'h0000_0077, 2, 1, 32'h0000_0077));
      run_vec(mk("ld108_postrst", 0, 32'h0000_0108, 4'hF, 32'h0, 2, 32'h0000_0108, 3, 1, 32'h0000_0108));
      run_vec(mk("ld100_rehit", 0, 32'h0000_0100, 4'hF, 32'h0, 1, 32'h0, 0, 0, 32'h0000_0077));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_dcache.md
# mem_dcache

Direct-mapped, write-through, no-write-allocate data cache in the MEM stage. It serves loads and stores from the MEM stage and raises `stallreq_o` while a miss refill or store write-through is outstanding on the memory bus. `stallreq_o` feeds the pipeline controller's `stallreq_from_mem_cache` input, which freezes PC through MEM (stall = 6'b011111) and holds the MEM-stage request stable until the cache releases it.

## Interface
- `INDEX_BITS`, default 6: number of line-index bits; the cache has 2^INDEX_BITS lines of one 32-bit word each.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `ce_i` input 1: MEM-stage access valid.
- `we_i` input 1: 1 = store, 0 = load.
- `addr_i` input 32: byte address, word-aligned (alignment is checked upstream).
- `sel_i` input 4: byte enables for stores; bit k selects bits [8k+7:8k].
- `wdata_i` input 32: store data, already lane-aligned.
- `rdata_o` output 32: load data.
- `stallreq_o` output 1: stall request to the pipeline controller.
- `mem_req_o` output 1: bus request, registered.
- `mem_we_o` output 1: bus write, registered.
- `mem_addr_o` output 32: bus address, registered.
- `mem_sel_o` output 4: bus byte enables, registered.
- `mem_wdata_o` output 32: bus write data, registered.
- `mem_rdata_i` input 32: bus read data, valid only when `mem_ack_i` = 1.
- `mem_ack_i` input 1: one-cycle completion pulse from the bus.

## Operation
- Address split: `tag` = addr_i[31:INDEX_BITS+2]; `index` = addr_i[INDEX_BITS+1:2]. Per line: valid bit, tag, 32-bit data.
- Hit = `ce_i` && valid[index] && tag match.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
- **IDLE**
  - Load hit: `rdata_o` = line data, driven combinationally. `stallreq_o` = 0. State stays IDLE.
  - Load miss: `stallreq_o` = 1 combinationally. At the next edge: `mem_req_o` = 1, `mem_we_o` = 0, `mem_addr_o` = {addr_i[31:2], 2'b00}, `mem_sel_o` = 4'b1111; go to RD_WAIT.
  - Store (hit or miss): `stallreq_o` = 1. At the next edge: `mem_req_o` = 1, `mem_we_o` = 1, and addr/sel/wdata are copied from the inputs; go to WR_WAIT.
  - `ce_i` = 0: `stallreq_o` = 0 and `rdata_o` = 0.
- **RD_WAIT**
  - `stallreq_o` = 1.
  - On `mem_ack_i`, at that edge: write the line (valid = 1, tag, `mem_rdata_i`), latch `mem_rdata_i` into the read buffer, set `mem_req_o` = 0, go to DONE.
- **WR_WAIT**
  - `stallreq_o` = 1.
  - On `mem_ack_i`: if the line hit (re-evaluated with the held inputs), merge the `sel_i` bytes of `wdata_i` into the line. No allocation on a miss. Set `mem_req_o` = 0 and go to DONE.
- **DONE**
  - `stallreq_o` = 0. `rdata_o` = read buffer for loads (0 for stores).
  - Go to IDLE unconditionally; the access is consumed at this edge.
- Bus outputs hold stable while `mem_req_o` = 1 and no ack has arrived.
- `mem_ack_i` is ignored in IDLE and DONE.

## Timing
- Reset (asynchronous, `rst` = 0):
  - All valid bits cleared, state IDLE, read buffer 0.
  - `mem_req_o`, `mem_we_o` = 0; `mem_addr_o`, `mem_sel_o`, `mem_wdata_o` = 0.
  - Combinational outputs settle to `stallreq_o` = 0 and `rdata_o` = 0.
- Reset in RD_WAIT or WR_WAIT abandons the bus transaction; a late ack after reset is ignored.
- Load hit: 0 stall cycles.
- Load miss or any store: `stallreq_o` high from the request cycle through the ack cycle inclusive, then low in DONE.
  - Total MEM occupancy = 2 + L cycles, where L = cycles from `mem_req_o` rising to `mem_ack_i`, L ≥ 1.
- Ack in the first cycle of RD_WAIT/WR_WAIT is legal (L = 1).
- Back-to-back accesses: the access after DONE is evaluated in the next IDLE cycle. A load to the same line just refilled must hit.
- A store that hits updates the array only at ack, so a load following the store sees the merged data.
- Index wrap: addresses differing only in tag evict each other (direct-mapped replacement, no writeback needed).

## Test plan
- After reset, load 0x0000_0100 with ack after 3 cycles returning 0xDEAD_BEEF → `stallreq_o` high 4 cycles; DONE `rdata_o` = 0xDEAD_BEEF; an immediate reload hits with 0 stall and the same data.
- Store 0x0000_0100, `sel_i` = 4'b0011, `wdata_i` = 0x0000_1234, ack L = 1 → bus write with sel 0011; a following load hits returning 0xDEAD_1234.
- Store to the uncached address 0x0000_0200 → bus write issued; a following load to 0x200 misses (no allocate).
- Conflict: load 0x0000_0100, then 0x0001_0100 (same index, `INDEX_BITS` = 6) → second misses; a third load to 0x100 misses again.
- Assert `rst` = 0 in RD_WAIT, then pulse `mem_ack_i` after release → FSM stays IDLE, no line valid, `stallreq_o` = 0, `mem_req_o` = 0.
- `ce_i` = 0 with a spurious `mem_ack_i` in IDLE → no state change, `stallreq_o` = 0, no bus request.
